// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
//   i2c_state_t : bus-side FSM states
//   I2C_WR/RD   : value of the R/W bit in the address byte
//   I2C_ACK/NACK: SDA level in the ninth clock
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } i2c_state_t;

  localparam logic I2C_WR   = 1'b0;
  localparam logic I2C_RD   = 1'b1;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int unsigned TimeoutW = 20;

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one raw I2C pad level: 2-FF synchronizer followed by a stability
// filter that accepts a new level only after it has been seen FILT_LEN
// consecutive cycles. Level resets to 1 (idle bus).
//   clk50, rst_n : clock, async active-low reset
//   raw          : raw pad level
//   level        : filtered level
//   rise, fall   : one-cycle pulses on filtered edges
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(FILT_LEN + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;
  logic            prev_q;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], raw};
      prev_q <= level_q;
      // Count consecutive cycles the synchronized value disagrees with the
      // accepted level; any agreement restarts the count.
      if (sync_q[1] != level_q) begin
        if (cnt_q == CntW'(FILT_LEN - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;
  assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit register file at address DEV_ADDR.
// Write: S addr+W, ptr, data... P. Read: S addr+R (or Sr after ptr), data...
// Register index is ptr mod NUM_REGS; ptr auto-increments (8-bit wrap).
// Optional macro I2C_TARGET_TIMEOUT_EN: 2^20-1 cycles without an SCL edge
// while busy forces the target back to idle and releases SDA.
//   clk50, rst_n : clock, async active-low reset
//   scl_i, sda_i : raw pad levels
//   sda_oe       : 1 = pull SDA low
//   wr_stb/wr_addr/wr_data : one-cycle write notification
//   rd_addr/rd_data        : combinational user readback
//   busy         : high from START to STOP
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h68,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk50(clk50), .rst_n(rst_n), .raw(scl_i),
    .level(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk50(clk50), .rst_n(rst_n), .raw(sda_i),
    .level(sda), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_cond, stop_cond;
  assign start_cond = sda_fall & scl;
  assign stop_cond  = sda_rise & scl;

  i2c_state_t     state_q;
  logic [2:0]     bit_cnt_q;
  logic [6:0]     shift_q;   // only 7 bits: the MSB goes straight onto sda_oe
  logic [7:0]     ptr_q;
  logic           rw_q;
  logic           ack_clk_q; // ninth SCL rising edge already seen
  logic           mack_q;    // master acknowledged the last read byte
  logic [7:0]     regs_q [NUM_REGS];

  logic [7:0]      rx_byte;
  logic [IdxW-1:0] ptr_idx;
  assign rx_byte = {shift_q, sda};
  assign ptr_idx = ptr_q[IdxW-1:0];

  logic timeout;
`ifdef I2C_TARGET_TIMEOUT_EN
  logic [TimeoutW-1:0] to_cnt_q;
  assign timeout = &to_cnt_q;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (!busy || scl_rise || scl_fall) begin
      to_cnt_q <= '0;
    end else if (!timeout) begin
      to_cnt_q <= to_cnt_q + TimeoutW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= I2C_WR;
      ack_clk_q <= 1'b0;
      mack_q    <= 1'b0;
      sda_oe    <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (timeout) begin
        state_q <= StIdle;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (start_cond) begin
        state_q   <= StAddr;
        bit_cnt_q <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
      end else if (stop_cond) begin
        state_q <= StIdle;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          StAddr, StPtr, StWdata: begin
            if (scl_rise) begin
              shift_q   <= rx_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_clk_q <= 1'b0;
                if (state_q == StAddr) begin
                  rw_q    <= sda;
                  state_q <= (rx_byte[7:1] == DEV_ADDR) ? StAddrAck : StIgnore;
                end else if (state_q == StPtr) begin
                  ptr_q   <= rx_byte;
                  state_q <= StPtrAck;
                end else begin
                  regs_q[ptr_idx] <= rx_byte;
                  wr_stb          <= 1'b1;
                  wr_addr         <= ptr_q;
                  wr_data         <= rx_byte;
                  ptr_q           <= ptr_q + 8'd1;
                  state_q         <= StWdataAck;
                end
              end
            end
          end
          StAddrAck, StPtrAck, StWdataAck: begin
            if (scl_rise) ack_clk_q <= 1'b1;
            if (scl_fall) begin
              if (!ack_clk_q) begin
                // Falling edge that ends bit 8: start driving ACK.
                sda_oe <= 1'b1;
              end else begin
                bit_cnt_q <= '0;
                if (state_q == StAddrAck && rw_q == I2C_RD) begin
                  state_q <= StRdata;
                  shift_q <= regs_q[ptr_idx][6:0];
                  sda_oe  <= ~regs_q[ptr_idx][7];
                end else begin
                  sda_oe  <= 1'b0;
                  state_q <= (state_q == StAddrAck) ? StPtr : StWdata;
                end
              end
            end
          end
          StRdata: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ack_clk_q <= 1'b0;
                state_q   <= StRdataAck;
              end
            end
            if (scl_fall) begin
              sda_oe  <= ~shift_q[6];
              shift_q <= {shift_q[5:0], 1'b0};
            end
          end
          StRdataAck: begin
            if (scl_rise) begin
              ack_clk_q <= 1'b1;
              mack_q    <= (sda == I2C_ACK);
              if (sda == I2C_ACK) ptr_q <= ptr_q + 8'd1;
            end
            if (scl_fall) begin
              if (!ack_clk_q) begin
                sda_oe <= 1'b0; // release for the master's ACK bit
              end else if (mack_q) begin
                state_q   <= StRdata;
                bit_cnt_q <= '0;
                shift_q   <= regs_q[ptr_idx][6:0];
                sda_oe    <= ~regs_q[ptr_idx][7];
              end else begin
                state_q <= StIgnore;
                sda_oe  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rd_data = regs_q[rd_addr[IdxW-1:0]];

  if (IdxW < 8) begin : g_unused_rd
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr[7:IdxW];
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Self-checking bench for i2c_target_regs: bit-banged I2C master, a table of
// single-write vectors, hand sequences for multi-cycle corners, and random
// transactions checked against a byte-level register/pointer model.
module tb_i2c_target_regs;

  localparam int unsigned NumRegs = 16;
  localparam int unsigned Q       = 12; // clk50 cycles per quarter SCL period

  logic       clk50 = 1'b0;
  logic       rst_n;
  logic       mscl, msda;
  logic       scl_i, sda_i;
  logic       sda_oe, wr_stb, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  assign scl_i = mscl;
  assign sda_i = msda & ~sda_oe; // wired-AND bus

  i2c_target_regs dut (
    .clk50(clk50), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i),
    .sda_oe(sda_oe), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always #10 clk50 = ~clk50;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic [15:0] obs_q[$];
  int          oe_cnt = 0;
  always @(negedge clk50) begin
    if (wr_stb) obs_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
  end

  // ---------------- reference model ----------------
  logic [7:0]  m_regs [NumRegs];
  logic [7:0]  m_ptr;
  logic [15:0] exp_q[$];
  int          obs_rd = 0;

  task automatic m_reset();
    for (int i = 0; i < NumRegs; i++) m_regs[i] = 8'h00;
    m_ptr = 8'h00;
    exp_q.delete();
  endtask

  task automatic m_wbyte(input logic [7:0] d);
    m_regs[m_ptr % NumRegs] = d;
    exp_q.push_back({m_ptr, d});
    m_ptr = m_ptr + 8'd1;
  endtask

  task automatic m_rbyte(input logic ack, output logic [7:0] d);
    d = m_regs[m_ptr % NumRegs];
    if (ack) m_ptr = m_ptr + 8'd1;
  endtask

  task automatic cmp_strobes(input string name);
    check({name, "_count"}, obs_q.size() - obs_rd, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_rd + i < obs_q.size()) check(name, obs_q[obs_rd+i], exp_q[i]);
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < NumRegs; i++) begin
      rd_addr = 8'(i + NumRegs * $urandom_range(0, 15));
      #1;
      check(name, rd_data, m_regs[i]);
    end
  endtask

  // ---------------- bus master ----------------
  task automatic bus_start();
    msda = 1'b1; tick(Q);
    mscl = 1'b1; tick(Q);
    msda = 1'b0; tick(Q);
    mscl = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    msda = 1'b0; tick(Q);
    mscl = 1'b1; tick(Q);
    msda = 1'b1; tick(Q);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    msda = b;    tick(Q);
    mscl = 1'b1; tick(Q);
    s = sda_i;   tick(Q);
    mscl = 1'b0; tick(Q);
  endtask

  task automatic bus_wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic bus_rbyte(input logic ack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      d = {d[6:0], s};
    end
    bus_bit(~ack, s);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(3);
    rst_n = 1'b1;
    mscl = 1'b1; msda = 1'b1; tick(Q);
    m_reset();
    obs_rd = obs_q.size();
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] abyte;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
    logic [7:0] rd_idx;
    logic [7:0] exp_rd;
  } vec_t;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[7];
    logic       ack;
    logic [7:0] d, e;
    int         oe0;

    vecs[0] = '{8'hD0, 8'h05, 8'hA5, 1'b1, 8'h05, 8'hA5};
    vecs[1] = '{8'hD0, 8'h0F, 8'h11, 1'b1, 8'h0F, 8'h11};
    vecs[2] = '{8'hD0, 8'h1F, 8'h22, 1'b1, 8'h0F, 8'h22}; // ptr aliases mod 16
    vecs[3] = '{8'hA0, 8'h03, 8'h77, 1'b0, 8'h03, 8'h00}; // wrong address
    vecs[4] = '{8'hD0, 8'h03, 8'h5A, 1'b1, 8'h13, 8'h5A}; // rd_addr aliases
    vecs[5] = '{8'hD2, 8'h03, 8'h99, 1'b0, 8'h03, 8'h5A}; // 0x69, neighbour
    vecs[6] = '{8'hD0, 8'hFF, 8'hC3, 1'b1, 8'h0F, 8'hC3};

    // Reset values
    mscl = 1'b1; msda = 1'b1; rd_addr = 8'h00; rst_n = 1'b0;
    tick(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1; tick(Q);
    m_reset();

    // Table: S addr [ptr data] P
    for (int v = 0; v < 7; v++) begin
      bus_start();
      bus_wbyte(vecs[v].abyte, ack);
      check("vec_addr_ack", ack, vecs[v].exp_ack);
      if (vecs[v].exp_ack) begin
        bus_wbyte(vecs[v].ptr, ack);  check("vec_ptr_ack", ack, 1);
        bus_wbyte(vecs[v].data, ack); check("vec_data_ack", ack, 1);
        m_ptr = vecs[v].ptr;
        m_wbyte(vecs[v].data);
      end
      bus_stop();
      cmp_strobes("vec_stb");
      rd_addr = vecs[v].rd_idx; #1;
      check("vec_rd", rd_data, vecs[v].exp_rd);
    end

    // Write 0xD0 05 A5 3C P
    do_reset();
    bus_start();
    check("w_busy_start", busy, 1);
    bus_wbyte(8'hD0, ack); check("w_ack_addr", ack, 1);
    bus_wbyte(8'h05, ack); check("w_ack_ptr", ack, 1);
    bus_wbyte(8'hA5, ack); check("w_ack_d0", ack, 1);
    bus_wbyte(8'h3C, ack); check("w_ack_d1", ack, 1);
    m_ptr = 8'h05; m_wbyte(8'hA5); m_wbyte(8'h3C);
    bus_stop();
    check("w_busy_stop", busy, 0);
    cmp_strobes("w_stb");
    rd_addr = 8'h06; #1; check("w_rd6", rd_data, 8'h3C);

    // Pointer write, Sr, read two bytes ACK then NACK
    bus_start();
    bus_wbyte(8'hD0, ack); check("r_ack_addr", ack, 1);
    bus_wbyte(8'h05, ack); check("r_ack_ptr", ack, 1);
    m_ptr = 8'h05;
    bus_start();
    bus_wbyte(8'hD1, ack); check("r_ack_addr_rd", ack, 1);
    bus_rbyte(1'b1, d); check("r_byte0", d, 8'hA5); m_rbyte(1'b1, e);
    bus_rbyte(1'b0, d); check("r_byte1", d, 8'h3C); m_rbyte(1'b0, e);
    check("r_oe_after_nack", sda_oe, 0);
    check("r_busy_before_stop", busy, 1);
    bus_stop();
    check("r_busy_after_stop", busy, 0);
    cmp_strobes("r_stb");

    // Wrong address: never drives SDA, no writes
    oe0 = oe_cnt;
    bus_start();
    bus_wbyte(8'hA0, ack); check("na_ack", ack, 0);
    bus_wbyte(8'h02, ack); check("na_ack2", ack, 0);
    bus_stop();
    check("na_oe_cycles", oe_cnt - oe0, 0);
    cmp_strobes("na_stb");
    check_regs("na_regs");

    // Pointer wrap across NUM_REGS
    bus_start();
    bus_wbyte(8'hD0, ack); bus_wbyte(8'h1F, ack);
    bus_wbyte(8'h11, ack); bus_wbyte(8'h22, ack);
    check("wrap_ack", ack, 1);
    m_ptr = 8'h1F; m_wbyte(8'h11); m_wbyte(8'h22);
    bus_stop();
    cmp_strobes("wrap_stb");
    rd_addr = 8'h0F; #1; check("wrap_rd15", rd_data, 8'h11);
    rd_addr = 8'h00; #1; check("wrap_rd0", rd_data, 8'h22);

    // Reset while the target drives a read bit low
    do_reset();
    bus_start();
    bus_wbyte(8'hD0, ack); bus_wbyte(8'h03, ack); bus_wbyte(8'h33, ack);
    bus_stop();
    bus_start();
    bus_wbyte(8'hD1, ack); check("mr_ack", ack, 1);
    check("mr_oe_driving", sda_oe, 1); // regs[4]=0, so bit 7 pulls low
    rst_n = 1'b0; #1;
    check("mr_oe_async", sda_oe, 0);
    check("mr_busy", busy, 0);
    check("mr_stb", wr_stb, 0);
    tick(2);
    rst_n = 1'b1;
    m_reset();
    msda = 1'b1; tick(Q);
    bus_stop();
    check("mr_busy_idle", busy, 0);
    obs_rd = obs_q.size();
    rd_addr = 8'h03; #1; check("mr_regs_cleared", rd_data, 8'h00);
    bus_start();
    bus_wbyte(8'hD0, ack); bus_wbyte(8'h07, ack); bus_wbyte(8'hE1, ack);
    check("mr_next_ack", ack, 1);
    m_ptr = 8'h07; m_wbyte(8'hE1);
    bus_stop();
    cmp_strobes("mr_next_stb");
    bus_start();
    bus_wbyte(8'hD0, ack); bus_wbyte(8'h07, ack);
    bus_start();
    bus_wbyte(8'hD1, ack);
    bus_rbyte(1'b0, d); check("mr_next_rd", d, 8'hE1);
    m_ptr = 8'h07; m_rbyte(1'b0, e);
    bus_stop();

    // SCL held high mid-byte: busy must hold (well short of any timeout)
    begin
      logic s;
      bus_start();
      bus_wbyte(8'hD0, ack);
      for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
      msda = 1'b0; tick(Q);
      mscl = 1'b1; tick(3000);
      check("hold_busy", busy, 1);
      mscl = 1'b0; tick(Q);
      bus_stop();
      check("hold_busy_stop", busy, 0);
      cmp_strobes("hold_stb");
    end

    // Randomized transactions against the model
    for (int t = 0; t < 10; t++) begin
      int         kind, n;
      logic [7:0] p, b;
      logic [6:0] a7;
      kind = $urandom_range(0, 3);
      n    = $urandom_range(1, 3);
      p    = 8'($urandom);
      if (kind == 0) begin
        bus_start();
        bus_wbyte(8'hD0, ack); check("rnd_w_ack_addr", ack, 1);
        bus_wbyte(p, ack);     check("rnd_w_ack_ptr", ack, 1);
        m_ptr = p;
        for (int i = 0; i < n; i++) begin
          b = 8'($urandom);
          bus_wbyte(b, ack); check("rnd_w_ack_data", ack, 1);
          m_wbyte(b);
        end
        bus_stop();
      end else if (kind == 1 || kind == 2) begin
        bus_start();
        if (kind == 1) begin
          bus_wbyte(8'hD0, ack); check("rnd_r_ack_addr", ack, 1);
          bus_wbyte(p, ack);     check("rnd_r_ack_ptr", ack, 1);
          m_ptr = p;
          bus_start();
        end
        bus_wbyte(8'hD1, ack); check("rnd_r_ack_rd", ack, 1);
        for (int i = 0; i < n; i++) begin
          bus_rbyte(i != n - 1, d);
          m_rbyte(i != n - 1, e);
          check("rnd_r_data", d, e);
        end
        check("rnd_r_oe_release", sda_oe, 0);
        bus_stop();
      end else begin
        a7 = 7'($urandom_range(0, 127));
        if (a7 == 7'h68) a7 = 7'h10;
        oe0 = oe_cnt;
        bus_start();
        bus_wbyte({a7, 1'($urandom)}, ack); check("rnd_na_ack", ack, 0);
        bus_stop();
        check("rnd_na_oe", oe_cnt - oe0, 0);
      end
      check("rnd_busy_idle", busy, 0);
      cmp_strobes("rnd_stb");
    end
    check_regs("rnd_regs");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- Synthesizable I2C target (responder): the other end of the I2C master path that programs the SI5324 over i2c_clk/i2c_data.
- Presents an 8-bit register file at a configurable 7-bit address.
- Used in loopback builds and on a second board header so the master's configuration sequences can be checked in hardware without an SI5324 fitted.
- Drives SDA open-drain only; SCL is input-only (no clock stretching).

Parameters:
- DEV_ADDR, 7'h68, 7-bit target address (SI5324 default).
- NUM_REGS, 16, register count, power of 2, 2..256.
- FILT_LEN, 4, clk50 cycles a synchronized SCL/SDA level must be stable before it is accepted.

Ports:
- clk50  input  1  system clock, 50 MHz; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- scl_i  input  1  raw SCL pad level.
- sda_i  input  1  raw SDA pad level.
- sda_oe  output  1  1 = pull SDA low (pad tristate handled outside).
- wr_stb  output  1  one-cycle pulse per register write.
- wr_addr  output  8  register index of the write.
- wr_data  output  8  byte written.
- rd_addr  input  8  user-side readback index.
- rd_data  output  8  combinational read of regs[rd_addr mod NUM_REGS].
- busy  output  1  high from START to STOP.

Behaviour:
- Input conditioning:
  - scl_i and sda_i pass through a 2-FF synchronizer, then a FILT_LEN stability filter.
  - Filtered levels reset to 1.
  - Edges are detected on the filtered signals.
- Bus conditions:
  - START = SDA falling while SCL high. STOP = SDA rising while SCL high.
  - START (including repeated START) from any state: go to ADDR, bit counter=0, sda_oe=0.
  - STOP from any state: go to IDLE, sda_oe=0, busy=0.
- Bit timing:
  - Data is sampled on the filtered SCL rising edge.
  - sda_oe changes only on the cycle after a filtered SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR:
  - Shift 8 bits, MSB first.
  - On address match: ADDR_ACK, sda_oe=1 for the 9th clock.
  - On mismatch: IGNORE, sda_oe stays 0, wait for START/STOP.
  - On the ACK falling edge: R/W=0 goes to PTR; R/W=1 goes to RDATA with the shifter loaded from regs[ptr].
- PTR:
  - Receive 8 bits into ptr, then ACK.
  - Then WDATA.
- WDATA:
  - Receive a byte, then ACK.
  - On the 8th-bit rising edge: write regs[ptr mod NUM_REGS], pulse wr_stb with wr_addr=ptr, then ptr<=ptr+1.
  - 8-bit wrap: 8'hFF goes to 8'h00.
- RDATA:
  - Drive sda_oe = ~shift[7] per bit.
  - After 8 bits: release SDA and sample the master's ACK on the 9th rising edge.
  - ACK (SDA=0): ptr+1, reload the shifter, stay in RDATA.
  - NACK: IGNORE until STOP or START.
  - ptr increments only on an acknowledged read byte.
- Out-of-range pointer:
  - Index = ptr mod NUM_REGS for both writes and reads.
  - ACK is always given.
- Repeated START:
  - ptr is retained, so write-pointer-then-Sr-read works.
- Register behaviour:
  - Register file reset value is 8'h00.
  - Writes from the bus only; no user write port.
- Reset mid-transfer:
  - All state returns to IDLE and sda_oe=0 immediately (asynchronous).
  - ptr=0, wr_stb=0, busy=0.
- Reset values: sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, FSM=IDLE.

Optional Feature:
- Macro: I2C_TARGET_TIMEOUT_EN.
- Defined:
  - A 20-bit counter runs while busy; it clears on any filtered SCL edge.
  - At 2^20-1 cycles (~21 ms) it forces IDLE, sda_oe=0, busy=0.
  - This recovers a target that is holding SDA low after the master aborted.
- Undefined:
  - No counter; only STOP, START or reset leave a state.

Decomposition:
- Package i2c_pkg:
  - i2c_state_t enum.
  - I2C_RD / I2C_WR bit constants.
  - ACK/NACK constants.
- Sub-module i2c_line_filter, instantiated twice (SCL, SDA):
  - Synchronizer plus stability filter.
  - Outputs level, rise and fall.
- The FSM and register file stay in i2c_target_regs.

Test Plan:
- Write 0xD0, 0x05, 0xA5, 0x3C, STOP -> ACK on all 4 bytes; wr_stb twice (addr 5 data A5, addr 6 data 3C); rd_addr=6 gives 0x3C.
- Write 0xD0 0x05, Sr, 0xD1, read 2 bytes with ACK then NACK -> SDA carries A5 then 3C; sda_oe=0 after the NACK; busy falls at STOP.
- Address 0xA0 -> no ACK (sda_oe never 1), no wr_stb, registers unchanged.
- NUM_REGS=16: write 0xD0, 0x1F, 0x11, 0x22 -> regs[15]=11, regs[0]=22; wr_addr shows 1F then 20.
- rst_n low while sda_oe=1 during a read bit -> sda_oe=0 in the same cycle; ptr=0; next transfer decodes normally.
- With I2C_TARGET_TIMEOUT_EN: hold SCL high mid-byte for 2^20 cycles -> busy=0, FSM IDLE. Without the macro: busy stays 1.
